// File: rtl/pipeline_sequencer_pkg.sv
// Shared types and constants for the pipeline hazard/stall sequencer.
// Control-word field positions mirror the ctrl_* pipeline registers.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MUL_WAIT = 2'd2
  } seq_state_e;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam int REGWRITE  = 21;
  localparam int RS_MSB    = 20;
  localparam int RS_LSB    = 16;
  localparam int RT_MSB    = 15;
  localparam int RT_LSB    = 11;
  localparam int DEST_MSB  = 10;
  localparam int DEST_LSB  = 6;
  localparam int USEIMM    = 5;
  localparam int MULSEL    = 4;
  localparam int MEMWR     = 3;
  localparam int MEM2REG   = 2;
  localparam int ALUOP_MSB = 1;
  localparam int ALUOP_LSB = 0;

  // r0 is hardwired to zero, so it never matches as a producer.
  function automatic logic reg_match(input logic we, input logic [4:0] dest,
                                     input logic [4:0] src);
    return we && (dest != 5'd0) && (dest == src);
  endfunction

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Hazard-field inputs and pipeline-control outputs of the sequencer.
// slave = sequencer side, master = pipeline/control side.
interface pipeline_sequencer_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_imm;
  logic [4:0]       ex_dest;
  logic             ex_reg_write;
  logic             ex_mem_to_reg;
  logic             ex_mul;
  logic [4:0]       mem_dest;
  logic             mem_reg_write;
  logic [4:0]       wb_dest;
  logic             wb_reg_write;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             id_ex_bubble;
  logic             ex_mem_bubble;
  logic             mul_start;
  logic             mul_busy;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_use_imm, ex_dest, ex_reg_write, ex_mem_to_reg, ex_mul,
           mem_dest, mem_reg_write, wb_dest, wb_reg_write,
    input  pc_en, if_id_en, id_ex_en, id_ex_bubble, ex_mem_bubble, mul_start,
           mul_busy, fwd_a, fwd_b, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_use_imm, ex_dest, ex_reg_write, ex_mem_to_reg, ex_mul,
           mem_dest, mem_reg_write, wb_dest, wb_reg_write,
    output pc_en, if_id_en, id_ex_en, id_ex_bubble, ex_mem_bubble, mul_start,
           mul_busy, fwd_a, fwd_b, stall_cycles
  );
endinterface

// File: rtl/pipeline_sequencer_forward_unit.sv
// EX operand forwarding select; EX/MEM result takes priority over MEM/WB.
module forward_unit
  import pipeline_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] mem_dest,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_dest,
  input  logic       wb_reg_write,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  always_comb begin
    fwd_a = FWD_REG;
    if (reg_match(mem_reg_write, mem_dest, ex_rs)) begin
      fwd_a = FWD_EXMEM;
    end else if (reg_match(wb_reg_write, wb_dest, ex_rs)) begin
      fwd_a = FWD_MEMWB;
    end
  end

  always_comb begin
    fwd_b = FWD_REG;
    if (reg_match(mem_reg_write, mem_dest, ex_rt)) begin
      fwd_b = FWD_EXMEM;
    end else if (reg_match(wb_reg_write, wb_dest, ex_rt)) begin
      fwd_b = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Hazard and stall controller for the 5-stage pipeline: load-use bubbles,
// multi-cycle multiplier hold, EX forwarding selects and a stall counter.
//
// state    | meaning
// RUN      | normal flow; detects multiply in EX and load-use hazards
// LD_STALL | one-cycle bubble after a load-use, everything advances
// MUL_WAIT | pipeline frozen while the multiplier computes
module pipeline_sequencer
  import pipeline_pkg::*;
#(
  parameter int MUL_LATENCY = 32,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_sequencer_if.slave  seq
);

  // The mul_start cycle plus MUL_LATENCY-1 frozen cycles give MUL_LATENCY
  // stall cycles, and EX/MEM captures the product MUL_LATENCY edges after
  // the operands were latched.
  localparam logic [7:0] MUL_LOAD = 8'(MUL_LATENCY);

  seq_state_e       state_q, state_d;
  logic [7:0]       mul_cnt_q, mul_cnt_d;
  logic             mul_busy_q, mul_busy_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [4:0]       ex_rs_q, ex_rs_d;
  logic [4:0]       ex_rt_q, ex_rt_d;

  logic             load_use;
  logic             ld_ex;
  logic             pc_en, if_id_en, id_ex_en;
  logic             id_ex_bubble, ex_mem_bubble, mul_start;
  logic [1:0]       fwd_a_raw, fwd_b_raw;

  assign ld_ex    = seq.ex_reg_write & seq.ex_mem_to_reg;
  assign load_use = reg_match(ld_ex, seq.ex_dest, seq.id_rs) |
                    (~seq.id_use_imm & reg_match(ld_ex, seq.ex_dest, seq.id_rt));

  always_comb begin
    state_d       = state_q;
    mul_cnt_d     = mul_cnt_q;
    mul_busy_d    = mul_busy_q;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mul_start     = 1'b0;

    unique case (state_q)
      RUN: begin
        if (seq.ex_mul) begin
          mul_start     = 1'b1;
          mul_cnt_d     = MUL_LOAD;
          mul_busy_d    = 1'b1;
          pc_en         = 1'b0;
          if_id_en      = 1'b0;
          id_ex_en      = 1'b0;
          ex_mem_bubble = 1'b1;
          state_d       = MUL_WAIT;
        end else if (load_use) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
          state_d      = LD_STALL;
        end
      end
      LD_STALL: begin
        state_d = RUN;
      end
      MUL_WAIT: begin
        if (mul_cnt_q > 8'd1) begin
          pc_en         = 1'b0;
          if_id_en      = 1'b0;
          id_ex_en      = 1'b0;
          ex_mem_bubble = 1'b1;
          mul_cnt_d     = mul_cnt_q - 8'd1;
        end else begin
          mul_cnt_d  = 8'd0;
          mul_busy_d = 1'b0;
          state_d    = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (rst) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      id_ex_bubble  = 1'b0;
      ex_mem_bubble = 1'b0;
      mul_start     = 1'b0;
    end

    ex_rs_d = ex_rs_q;
    ex_rt_d = ex_rt_q;
    if (id_ex_en) begin
      ex_rs_d = id_ex_bubble ? 5'd0 : seq.id_rs;
      ex_rt_d = id_ex_bubble ? 5'd0 : seq.id_rt;
    end

    stall_d = stall_q;
    if (!pc_en && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      mul_cnt_q  <= 8'd0;
      mul_busy_q <= 1'b0;
      stall_q    <= '0;
      ex_rs_q    <= 5'd0;
      ex_rt_q    <= 5'd0;
    end else begin
      state_q    <= state_d;
      mul_cnt_q  <= mul_cnt_d;
      mul_busy_q <= mul_busy_d;
      stall_q    <= stall_d;
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
    end
  end

  forward_unit u_forward_unit (
    .ex_rs         (ex_rs_q),
    .ex_rt         (ex_rt_q),
    .mem_dest      (seq.mem_dest),
    .mem_reg_write (seq.mem_reg_write),
    .wb_dest       (seq.wb_dest),
    .wb_reg_write  (seq.wb_reg_write),
    .fwd_a         (fwd_a_raw),
    .fwd_b         (fwd_b_raw)
  );

  assign seq.pc_en         = pc_en;
  assign seq.if_id_en      = if_id_en;
  assign seq.id_ex_en      = id_ex_en;
  assign seq.id_ex_bubble  = id_ex_bubble;
  assign seq.ex_mem_bubble = ex_mem_bubble;
  assign seq.mul_start     = mul_start;
  assign seq.mul_busy      = mul_busy_q;
  assign seq.fwd_a         = rst ? FWD_REG : fwd_a_raw;
  assign seq.fwd_b         = rst ? FWD_REG : fwd_b_raw;
  assign seq.stall_cycles  = stall_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: directed per-cycle vectors push
// expected outputs, an independent monitor pops and compares each cycle.
module tb_pipeline_sequencer;
  import pipeline_pkg::*;

  localparam int CNT_W = 4;
  localparam int LAT   = 4;

  // {pc_en, if_id_en, id_ex_en, id_ex_bubble, ex_mem_bubble, mul_start, mul_busy}
  localparam logic [6:0] C_RST  = 7'b0000000;
  localparam logic [6:0] C_RUN  = 7'b1110000;
  localparam logic [6:0] C_LDU  = 7'b0011000;
  localparam logic [6:0] C_MST  = 7'b0000110;
  localparam logic [6:0] C_MW   = 7'b0000101;
  localparam logic [6:0] C_MFIN = 7'b1110001;
  localparam logic [6:0] C_RSTB = 7'b0000001;

  typedef struct {
    string            name;
    logic [6:0]       ctrl;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic [CNT_W-1:0] stall;
  } exp_t;

  logic clk;
  logic rst;
  exp_t exp_q[$];
  int   checks;
  int   failures;
  logic [CNT_W-1:0] model_stall;

  pipeline_sequencer_if #(.CNT_W(CNT_W)) seq_if ();

  pipeline_sequencer #(.MUL_LATENCY(LAT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .seq (seq_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [21:0] cw(input logic rw, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] dest,
                                     input logic imm, input logic mul,
                                     input logic memwr, input logic m2r,
                                     input logic [1:0] alu);
    logic [21:0] w;
    w = '0;
    w[REGWRITE]            = rw;
    w[RS_MSB:RS_LSB]       = rs;
    w[RT_MSB:RT_LSB]       = rt;
    w[DEST_MSB:DEST_LSB]   = dest;
    w[USEIMM]              = imm;
    w[MULSEL]              = mul;
    w[MEMWR]               = memwr;
    w[MEM2REG]             = m2r;
    w[ALUOP_MSB:ALUOP_LSB] = alu;
    return w;
  endfunction

  task automatic drive(input logic [21:0] idw, input logic [21:0] exw,
                       input logic [4:0] md, input logic mw,
                       input logic [4:0] wd, input logic ww);
    seq_if.id_rs         = idw[RS_MSB:RS_LSB];
    seq_if.id_rt         = idw[RT_MSB:RT_LSB];
    seq_if.id_use_imm    = idw[USEIMM];
    seq_if.ex_dest       = exw[DEST_MSB:DEST_LSB];
    seq_if.ex_reg_write  = exw[REGWRITE];
    seq_if.ex_mem_to_reg = exw[MEM2REG];
    seq_if.ex_mul        = exw[MULSEL];
    seq_if.mem_dest      = md;
    seq_if.mem_reg_write = mw;
    seq_if.wb_dest       = wd;
    seq_if.wb_reg_write  = ww;
  endtask

  // One clock cycle: apply rst, queue the expected outputs, advance.
  task automatic step(input string nm, input logic r, input logic [6:0] c,
                      input logic [1:0] fa, input logic [1:0] fb);
    exp_t e;
    rst     = r;
    e.name  = nm;
    e.ctrl  = c;
    e.fa    = fa;
    e.fb    = fb;
    e.stall = model_stall;
    exp_q.push_back(e);
    if (r) model_stall = '0;
    else if (!c[6] && model_stall != {CNT_W{1'b1}}) model_stall = model_stall + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_mul(input string nm, input logic [21:0] idw, input logic [21:0] exw);
    drive(idw, exw, 5'd0, 1'b0, 5'd0, 1'b0);
    step({nm, "_start"}, 1'b0, C_MST, 2'b00, 2'b00);
    for (int i = 0; i < LAT - 1; i++) step({nm, "_wait"}, 1'b0, C_MW, 2'b00, 2'b00);
    step({nm, "_final"}, 1'b0, C_MFIN, 2'b00, 2'b00);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {seq_if.pc_en, seq_if.if_id_en, seq_if.id_ex_en, seq_if.id_ex_bubble,
               seq_if.ex_mem_bubble, seq_if.mul_start, seq_if.mul_busy};
        checks++;
        if (act !== e.ctrl || seq_if.fwd_a !== e.fa || seq_if.fwd_b !== e.fb ||
            seq_if.stall_cycles !== e.stall) begin
          failures++;
          $display("FAIL %s: got ctrl=%b fwd_a=%b fwd_b=%b stall=%0d, expected ctrl=%b fwd_a=%b fwd_b=%b stall=%0d",
                   e.name, act, seq_if.fwd_a, seq_if.fwd_b, seq_if.stall_cycles,
                   e.ctrl, e.fa, e.fb, e.stall);
        end
      end
    end
  end

  initial begin : stimulus
    logic [21:0] nop, lw5, lw0, mul, mulld, rd5, rt5imm, rt5, rd0, st73;
    int          guard;
    checks      = 0;
    failures    = 0;
    model_stall = '0;
    nop    = '0;
    lw5    = cw(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
    lw0    = cw(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
    mul    = cw(1'b1, 5'd1, 5'd2, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10);
    mulld  = cw(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00);
    rd5    = cw(1'b1, 5'd5, 5'd0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
    rt5imm = cw(1'b1, 5'd0, 5'd5, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10);
    rt5    = cw(1'b1, 5'd0, 5'd5, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
    rd0    = cw(1'b1, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
    st73   = cw(1'b0, 5'd7, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);

    rst = 1'b1;
    drive(nop, nop, 5'd0, 1'b0, 5'd0, 1'b0);
    @(posedge clk);
    #1;

    step("rst_init0", 1'b1, C_RST, 2'b00, 2'b00);
    step("rst_init1", 1'b1, C_RST, 2'b00, 2'b00);
    step("run_idle", 1'b0, C_RUN, 2'b00, 2'b00);

    // Traffic with forwarding live, then a three-cycle reset over it.
    drive(st73, nop, 5'd7, 1'b1, 5'd7, 1'b1);
    step("traffic0", 1'b0, C_RUN, 2'b00, 2'b00);
    step("traffic1", 1'b0, C_RUN, 2'b01, 2'b00);
    drive(st73, mul, 5'd7, 1'b1, 5'd7, 1'b1);
    for (int i = 0; i < 3; i++) step("rst_mid", 1'b1, C_RST, 2'b00, 2'b00);
    drive(nop, nop, 5'd0, 1'b0, 5'd0, 1'b0);
    step("rst_release", 1'b0, C_RUN, 2'b00, 2'b00);

    // Load-use hazards.
    drive(rd5, lw5, 5'd0, 1'b0, 5'd0, 1'b0);
    step("ldu_rs", 1'b0, C_LDU, 2'b00, 2'b00);
    drive(rd5, nop, 5'd0, 1'b0, 5'd0, 1'b0);
    step("ldu_rs_bubble", 1'b0, C_RUN, 2'b00, 2'b00);
    drive(rt5imm, lw5, 5'd0, 1'b0, 5'd0, 1'b0);
    step("ldu_rt_imm", 1'b0, C_RUN, 2'b00, 2'b00);
    drive(rd0, lw0, 5'd0, 1'b0, 5'd0, 1'b0);
    step("ldu_r0", 1'b0, C_RUN, 2'b00, 2'b00);
    drive(rt5, lw5, 5'd0, 1'b0, 5'd0, 1'b0);
    step("ldu_rt", 1'b0, C_LDU, 2'b00, 2'b00);
    drive(rt5, nop, 5'd0, 1'b0, 5'd0, 1'b0);
    step("ldu_rt_bubble", 1'b0, C_RUN, 2'b00, 2'b00);

    // Forwarding (ex copies hold rs=0, rt=5 on entry).
    drive(st73, nop, 5'd7, 1'b1, 5'd7, 1'b1);
    step("fwd_load", 1'b0, C_RUN, 2'b00, 2'b00);
    step("fwd_a_exmem", 1'b0, C_RUN, 2'b01, 2'b00);
    drive(st73, nop, 5'd7, 1'b0, 5'd7, 1'b1);
    step("fwd_a_memwb", 1'b0, C_RUN, 2'b10, 2'b00);
    drive(st73, nop, 5'd7, 1'b0, 5'd3, 1'b1);
    step("fwd_b_memwb", 1'b0, C_RUN, 2'b00, 2'b10);
    drive(nop, nop, 5'd3, 1'b1, 5'd7, 1'b1);
    step("fwd_both", 1'b0, C_RUN, 2'b10, 2'b01);
    drive(nop, nop, 5'd0, 1'b1, 5'd0, 1'b1);
    step("fwd_r0", 1'b0, C_RUN, 2'b00, 2'b00);

    // Multiply from a clean counter.
    drive(nop, nop, 5'd0, 1'b0, 5'd0, 1'b0);
    step("pre_mul_rst", 1'b1, C_RST, 2'b00, 2'b00);
    run_mul("mul", nop, mul);
    drive(nop, nop, 5'd0, 1'b0, 5'd0, 1'b0);
    step("mul_done", 1'b0, C_RUN, 2'b00, 2'b00);

    // Multiply and load-use together: multiply first, bubble afterwards.
    run_mul("simul", rd5, mulld);
    drive(rd5, lw5, 5'd0, 1'b0, 5'd0, 1'b0);
    step("simul_ldu", 1'b0, C_LDU, 2'b00, 2'b00);
    drive(rd5, nop, 5'd0, 1'b0, 5'd0, 1'b0);
    step("simul_bubble", 1'b0, C_RUN, 2'b00, 2'b00);

    // Reset while mul_cnt=2 aborts the multiply.
    drive(nop, mul, 5'd0, 1'b0, 5'd0, 1'b0);
    step("abort_start", 1'b0, C_MST, 2'b00, 2'b00);
    step("abort_wait4", 1'b0, C_MW, 2'b00, 2'b00);
    step("abort_wait3", 1'b0, C_MW, 2'b00, 2'b00);
    step("abort_rst", 1'b1, C_RSTB, 2'b00, 2'b00);
    drive(nop, nop, 5'd0, 1'b0, 5'd0, 1'b0);
    step("abort_run", 1'b0, C_RUN, 2'b00, 2'b00);
    step("abort_idle", 1'b0, C_RUN, 2'b00, 2'b00);

    // Five back-to-back multiplies: 20 stall cycles saturate a 4-bit counter.
    step("sat_rst", 1'b1, C_RST, 2'b00, 2'b00);
    for (int k = 0; k < 5; k++) run_mul("sat", nop, mul);
    drive(nop, nop, 5'd0, 1'b0, 5'd0, 1'b0);
    step("sat_done", 1'b0, C_RUN, 2'b00, 2'b00);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries never compared, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
